// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with storage, pointers, status flags, fill level and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module sync_fifo_ctrl #(
    parameter int DATA_WD   = 8,
    parameter int DEPTH     = 8,
    parameter int PTR_WD    = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               w_enbl,
    input  logic [DATA_WD-1:0] data_in,
    input  logic               r_enbl,
    output logic [DATA_WD-1:0] data_out,
    output logic               full_flag,
    output logic               empty_flag,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [PTR_WD:0]    level,
    output logic               overflow,
    output logic               underflow,
    input  logic               err_clr
);

    localparam logic [PTR_WD:0] DEPTH_L = (PTR_WD+1)'(DEPTH);
    localparam logic [PTR_WD:0] AF_L    = (PTR_WD+1)'(AF_THRESH);
    localparam logic [PTR_WD:0] AE_L    = (PTR_WD+1)'(AE_THRESH);

    logic [DATA_WD-1:0] mem [DEPTH];
    logic [PTR_WD:0]    wr_ptr;
    logic [PTR_WD:0]    rd_ptr;
    logic               wr_acc;
    logic               rd_acc;

    // Flags derive from registered pointers only, so request inputs never reach them.
    assign level        = wr_ptr - rd_ptr;
    assign full_flag    = (level == DEPTH_L);
    assign empty_flag   = (level == '0);
    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);

    assign wr_acc = w_enbl && !full_flag;
    assign rd_acc = r_enbl && !empty_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            // A fresh error in the same cycle as err_clr keeps the bit set.
            overflow  <= (w_enbl && full_flag) || (overflow && !err_clr);
            underflow <= (r_enbl && empty_flag) || (underflow && !err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[PTR_WD-1:0]] <= data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = empty_flag ? '0 : mem[rd_ptr[PTR_WD-1:0]];
`else
    logic [DATA_WD-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem[rd_ptr[PTR_WD-1:0]];
        end
    end

    assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl (DEPTH 8, AF 6, AE 2).
// Expectations follow SYNC_FIFO_FWFT_EN when the macro is defined for the build.
module tb_sync_fifo_ctrl;

`ifdef SYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       w_enbl;
    logic [7:0] data_in;
    logic       r_enbl;
    logic [7:0] data_out;
    logic       full_flag;
    logic       empty_flag;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] level;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int n_checks = 0;
    int n_pass   = 0;

    sync_fifo_ctrl #(
        .DATA_WD(8), .DEPTH(8), .PTR_WD(3), .AF_THRESH(6), .AE_THRESH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .w_enbl(w_enbl), .data_in(data_in),
        .r_enbl(r_enbl), .data_out(data_out), .full_flag(full_flag),
        .empty_flag(empty_flag), .almost_full(almost_full),
        .almost_empty(almost_empty), .level(level), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of requests, let the edge happen, sample 1 time unit later.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        w_enbl  = w;
        data_in = d;
        r_enbl  = r;
        err_clr = c;
        @(posedge clk);
        #1;
        w_enbl  = 1'b0;
        r_enbl  = 1'b0;
        err_clr = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++; if (level !== 4'd0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
        n_checks++; if (empty_flag !== 1'b1) $display("FAIL reset_empty got %b want 1", empty_flag); else n_pass++;
        n_checks++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got %b want 1", almost_empty); else n_pass++;
        n_checks++; if (full_flag !== 1'b0 || almost_full !== 1'b0) $display("FAIL reset_full got %b%b want 00", full_flag, almost_full); else n_pass++;
        n_checks++; if (data_out !== 8'h00) $display("FAIL reset_dout got %h want 00", data_out); else n_pass++;
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL reset_err got %b%b want 00", overflow, underflow); else n_pass++;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (level !== 4'd0 || empty_flag !== 1'b1) $display("FAIL idle_state got lvl %0d empty %b want 0/1", level, empty_flag); else n_pass++;
    endtask

    task automatic test_first_word();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        n_checks++; if (level !== 4'd1 || empty_flag !== 1'b0) $display("FAIL fw_level got %0d/%b want 1/0", level, empty_flag); else n_pass++;
        n_checks++; if (data_out !== (FWFT ? 8'hA5 : 8'h00)) $display("FAIL fw_visible got %h want %h", data_out, FWFT ? 8'hA5 : 8'h00); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (data_out !== (FWFT ? 8'hA5 : 8'h00)) $display("FAIL fw_hold got %h want %h", data_out, FWFT ? 8'hA5 : 8'h00); else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (data_out !== (FWFT ? 8'h00 : 8'hA5)) $display("FAIL fw_read got %h want %h", data_out, FWFT ? 8'h00 : 8'hA5); else n_pass++;
        n_checks++; if (empty_flag !== 1'b1) $display("FAIL fw_empty got %b want 1", empty_flag); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        n_checks++; if (level !== 4'd3) $display("FAIL mid_level got %0d want 3", level); else n_pass++;
        rst_n = 1'b0;
        #2;
        n_checks++; if (level !== 4'd0 || empty_flag !== 1'b1 || data_out !== 8'h00) $display("FAIL mid_reset got lvl %0d empty %b dout %h want 0/1/00", level, empty_flag, data_out); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_fill_overflow();
        logic [7:0] exp_d;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 8'(k), 1'b0, 1'b0);
            n_checks++; if (level !== 4'(k)) $display("FAIL fill_level[%0d] got %0d want %0d", k, level, k); else n_pass++;
            n_checks++; if (almost_full !== (k >= 6)) $display("FAIL fill_af[%0d] got %b want %b", k, almost_full, k >= 6); else n_pass++;
            n_checks++; if (almost_empty !== (k <= 2)) $display("FAIL fill_ae[%0d] got %b want %b", k, almost_empty, k <= 2); else n_pass++;
        end
        n_checks++; if (full_flag !== 1'b1) $display("FAIL fill_full got %b want 1", full_flag); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL fill_no_ovf got %b want 0", overflow); else n_pass++;
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else n_pass++;
        n_checks++; if (level !== 4'd8 || full_flag !== 1'b1) $display("FAIL ovf_level got %0d/%b want 8/1", level, full_flag); else n_pass++;
        n_checks++; if (data_out !== (FWFT ? 8'h01 : 8'h00)) $display("FAIL ovf_dout got %h want %h", data_out, FWFT ? 8'h01 : 8'h00); else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            exp_d = FWFT ? ((k < 8) ? 8'(k + 1) : 8'h00) : 8'(k);
            n_checks++; if (data_out !== exp_d) $display("FAIL drain_data[%0d] got %h want %h", k, data_out, exp_d); else n_pass++;
            n_checks++; if (level !== 4'(8 - k)) $display("FAIL drain_level[%0d] got %0d want %0d", k, level, 8 - k); else n_pass++;
            n_checks++; if (almost_full !== ((8 - k) >= 6)) $display("FAIL drain_af[%0d] got %b want %b", k, almost_full, (8 - k) >= 6); else n_pass++;
            n_checks++; if (almost_empty !== ((8 - k) <= 2)) $display("FAIL drain_ae[%0d] got %b want %b", k, almost_empty, (8 - k) <= 2); else n_pass++;
        end
        n_checks++; if (empty_flag !== 1'b1) $display("FAIL drain_empty got %b want 1", empty_flag); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_underflow();
        logic [7:0] held;
        held = FWFT ? 8'h00 : 8'h08;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (underflow !== 1'b1) $display("FAIL unf_set got %b want 1", underflow); else n_pass++;
        n_checks++; if (data_out !== held) $display("FAIL unf_dout got %h want %h", data_out, held); else n_pass++;
        n_checks++; if (level !== 4'd0) $display("FAIL unf_level got %0d want 0", level); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (underflow !== 1'b1) $display("FAIL unf_sticky got %b want 1", underflow); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if (underflow !== 1'b0) $display("FAIL unf_clr got %b want 0", underflow); else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++; if (underflow !== 1'b1) $display("FAIL unf_set_wins got %b want 1", underflow); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if (underflow !== 1'b0) $display("FAIL unf_clr2 got %b want 0", underflow); else n_pass++;
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_d;
        for (int k = 0; k < 8; k++) step(1'b1, 8'h10 + 8'(k), 1'b0, 1'b0);
        n_checks++; if (full_flag !== 1'b1) $display("FAIL frw_full got %b want 1", full_flag); else n_pass++;
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        n_checks++; if (level !== 4'd7 || full_flag !== 1'b0) $display("FAIL frw_level got %0d/%b want 7/0", level, full_flag); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL frw_ovf got %b want 1", overflow); else n_pass++;
        exp_d = FWFT ? 8'h11 : 8'h10;
        n_checks++; if (data_out !== exp_d) $display("FAIL frw_dout got %h want %h", data_out, exp_d); else n_pass++;
        for (int j = 1; j < 8; j++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            exp_d = FWFT ? ((j < 7) ? 8'h11 + 8'(j) : 8'h00) : 8'h10 + 8'(j);
            n_checks++; if (data_out !== exp_d) $display("FAIL frw_data[%0d] got %h want %h", j, data_out, exp_d); else n_pass++;
        end
        n_checks++; if (empty_flag !== 1'b1) $display("FAIL frw_empty got %b want 1", empty_flag); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_empty_rw();
        step(1'b1, 8'h55, 1'b1, 1'b0);
        n_checks++; if (level !== 4'd1 || empty_flag !== 1'b0) $display("FAIL erw_level got %0d/%b want 1/0", level, empty_flag); else n_pass++;
        n_checks++; if (underflow !== 1'b1) $display("FAIL erw_unf got %b want 1", underflow); else n_pass++;
        n_checks++; if (data_out !== (FWFT ? 8'h55 : 8'h17)) $display("FAIL erw_dout got %h want %h", data_out, FWFT ? 8'h55 : 8'h17); else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++; if (data_out !== (FWFT ? 8'h00 : 8'h55)) $display("FAIL erw_read got %h want %h", data_out, FWFT ? 8'h00 : 8'h55); else n_pass++;
        n_checks++; if (underflow !== 1'b0) $display("FAIL erw_clr got %b want 0", underflow); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        for (int k = 0; k < 4; k++) step(1'b1, 8'h20 + 8'(k), 1'b0, 1'b0);
        n_checks++; if (level !== 4'd4) $display("FAIL b2b_prefill got %0d want 4", level); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'h24 + 8'(i), 1'b1, 1'b0);
            exp_d = FWFT ? 8'h21 + 8'(i) : 8'h20 + 8'(i);
            n_checks++; if (level !== 4'd4) $display("FAIL b2b_level[%0d] got %0d want 4", i, level); else n_pass++;
            n_checks++; if (data_out !== exp_d) $display("FAIL b2b_data[%0d] got %h want %h", i, data_out, exp_d); else n_pass++;
        end
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            exp_d = FWFT ? ((j < 3) ? 8'h35 + 8'(j) : 8'h00) : 8'h34 + 8'(j);
            n_checks++; if (data_out !== exp_d) $display("FAIL b2b_drain[%0d] got %h want %h", j, data_out, exp_d); else n_pass++;
        end
        n_checks++; if (empty_flag !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL b2b_end got empty %b ovf %b unf %b want 1/0/0", empty_flag, overflow, underflow); else n_pass++;
    endtask

    initial begin
        rst_n   = 1'b1;
        w_enbl  = 1'b0;
        r_enbl  = 1'b0;
        err_clr = 1'b0;
        data_in = 8'h00;
        test_reset();
        test_first_word();
        test_reset_mid();
        test_fill_overflow();
        test_underflow();
        test_full_rw();
        test_empty_rw();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
